// File: rtl/motor_pkg.sv
// motor_pkg: state encodings and steering codes shared by the motor drive and direction stage
package motor_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        BRAKE = 2'b10
    } state_t;
    localparam logic [3:0] DIR_STRAIGHT = 4'b0000;
    localparam logic [3:0] DIR_LEFT     = 4'b0101;
    localparam logic [3:0] DIR_RIGHT    = 4'b1001;
    localparam logic [3:0] DIR_STOP     = 4'b1111;
    function automatic logic is_run_cmd(input logic [3:0] d);
        return (d == DIR_STRAIGHT) || (d == DIR_LEFT) || (d == DIR_RIGHT);
    endfunction
endpackage

// File: rtl/pwm_ramp_channel.sv
// pwm_ramp_channel: soft-start duty ramp, wrap-synchronous duty latch and PWM compare for one wheel
module pwm_ramp_channel
    import motor_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] i_target,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_tick,
    input  logic                i_wrap,
    input  logic                i_ramp,
    input  logic                i_clear,
    output logic                o_pwm
);
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);
    logic [PWM_BITS-1:0] r_cur;
    logic [PWM_BITS-1:0] r_act;
    logic [PWM_BITS-1:0] w_diff;
    logic [PWM_BITS-1:0] w_next;
    logic                w_up;
    // Next ramp value: the difference is taken in the direction that cannot underflow,
    // and a full step is only taken when it cannot overshoot the target
    always_comb begin
        w_up   = i_target > r_cur;
        w_diff = w_up ? i_target - r_cur : r_cur - i_target;
        w_next = (w_diff <= STEP) ? i_target : (w_up ? r_cur + STEP : r_cur - STEP);
    end
    // Current duty: forced to zero outside RUN, stepped once per ramp tick in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cur <= '0;
        else
            r_cur <= i_clear ? '0 : (i_ramp && i_tick) ? w_next : r_cur;
    end
    // Active duty only changes at the PWM period boundary so no pulse is ever truncated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_act <= '0;
        else if (i_wrap)
            r_act <= r_cur;
    end
    assign o_pwm = i_pwm_cnt < r_act;
endmodule

// File: rtl/motor_drive.sv
// motor_drive: steering command to H-bridge drive with soft-start PWM and timed active brake
module motor_drive
    import motor_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int FULL_DUTY    = 255,
    parameter int SLOW_DUTY    = 96,
    parameter int RAMP_STEP    = 8,
    parameter int RAMP_DIV     = 25_000,
    parameter int BRAKE_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_dir,
    output logic       o_en_l,
    output logic       o_en_r,
    output logic       o_in1_l,
    output logic       o_in2_l,
    output logic       o_in1_r,
    output logic       o_in2_r,
    output logic [1:0] o_state
);
    localparam int BW = $clog2(BRAKE_CYCLES + 1);
    localparam int TW = $clog2(RAMP_DIV + 1);
    localparam logic [PWM_BITS-1:0] FULL = PWM_BITS'(FULL_DUTY);
    localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'(SLOW_DUTY);
    logic [3:0]          r_dir_q;
    state_t              r_state;
    logic [BW-1:0]       r_brk_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [TW-1:0]       r_tick_cnt;
    logic                r_in1;
    logic                r_in2;
    logic                w_stop;
    logic                w_tick;
    logic                w_wrap;
    logic                w_ramp;
    logic [PWM_BITS-1:0] w_tgt_l;
    logic [PWM_BITS-1:0] w_tgt_r;
    logic                w_pwm_l;
    logic                w_pwm_r;
    // Command register; resets to stop so a release always takes two clocks to reach RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dir_q <= DIR_STOP;
        else
            r_dir_q <= i_dir;
    end
    // Decode, shared timebase strobes, and ramp gating (ramp only while RUN is being held)
    always_comb begin
        w_stop  = !is_run_cmd(r_dir_q);
        w_tick  = r_tick_cnt == TW'(RAMP_DIV - 1);
        w_wrap  = &r_pwm_cnt;
        w_ramp  = (r_state == RUN) && !w_stop;
        w_tgt_l = (r_dir_q == DIR_LEFT) ? SLOW : FULL;
        w_tgt_r = (r_dir_q == DIR_RIGHT) ? SLOW : FULL;
    end
    // Free-running PWM counter and ramp tick divider, independent of FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt  <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end
    // Drive FSM with registered bridge direction inputs; the brake cannot be interrupted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_brk_cnt <= '0;
            r_in1     <= 1'b0;
            r_in2     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_stop) begin
                        r_state <= RUN;
                        r_in1   <= 1'b1;
                        r_in2   <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_stop) begin
                        r_state   <= BRAKE;
                        r_brk_cnt <= '0;
                        r_in1     <= 1'b1;
                        r_in2     <= 1'b1;
                    end
                end
                BRAKE: begin
                    if (r_brk_cnt == BW'(BRAKE_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_in1   <= 1'b0;
                        r_in2   <= 1'b0;
                    end else begin
                        r_brk_cnt <= r_brk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= BRAKE;
                    r_brk_cnt <= '0;
                    r_in1     <= 1'b1;
                    r_in2     <= 1'b1;
                end
            endcase
        end
    end
    pwm_ramp_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_target (w_tgt_l),
        .i_pwm_cnt(r_pwm_cnt),
        .i_tick   (w_tick),
        .i_wrap   (w_wrap),
        .i_ramp   (w_ramp),
        .i_clear  (!w_ramp),
        .o_pwm    (w_pwm_l)
    );
    pwm_ramp_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_target (w_tgt_r),
        .i_pwm_cnt(r_pwm_cnt),
        .i_tick   (w_tick),
        .i_wrap   (w_wrap),
        .i_ramp   (w_ramp),
        .i_clear  (!w_ramp),
        .o_pwm    (w_pwm_r)
    );
    assign o_en_l  = (r_state == BRAKE) || ((r_state == RUN) && w_pwm_l);
    assign o_en_r  = (r_state == BRAKE) || ((r_state == RUN) && w_pwm_r);
    assign o_in1_l = r_in1;
    assign o_in2_l = r_in2;
    assign o_in1_r = r_in1;
    assign o_in2_r = r_in2;
    assign o_state = r_state;
endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed checks of reset, ramp, veer, brake timing and abort behaviour
module tb_motor_drive;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dir = 4'b0000;
    logic       en_l, en_r, in1_l, in2_l, in1_r, in2_r;
    logic [1:0] state;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         hi_l, hi_r, ok;

    motor_drive #(
        .PWM_BITS(4), .FULL_DUTY(15), .SLOW_DUTY(6),
        .RAMP_STEP(4), .RAMP_DIV(8), .BRAKE_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_dir(dir),
        .o_en_l(en_l), .o_en_r(en_r),
        .o_in1_l(in1_l), .o_in2_l(in2_l), .o_in1_r(in1_r), .o_in2_r(in2_r),
        .o_state(state)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_en_l", 32'(en_l), 0);
        chk("rst_en_r", 32'(en_r), 0);
        chk("rst_in1_l", 32'(in1_l), 0);
        chk("rst_in2_r", 32'(in2_r), 0);
        rst_n = 1'b1;
        wait_cyc(1);  chk("rel_idle", 32'(state), 0);
        wait_cyc(2);  chk("rel_run", 32'(state), 1);
        chk("run_in1_l", 32'(in1_l), 1);
        chk("run_in2_l", 32'(in2_l), 0);
        wait_cyc(8);  chk("up_l_4", 32'(dut.u_left.r_cur), 4);
        chk("up_r_4", 32'(dut.u_right.r_cur), 4);
        wait_cyc(16); chk("up_l_8", 32'(dut.u_left.r_cur), 8);
        chk("act_l_4", 32'(dut.u_left.r_act), 4);
        wait_cyc(24); chk("up_l_12", 32'(dut.u_left.r_cur), 12);
        wait_cyc(32); chk("up_l_15", 32'(dut.u_left.r_cur), 15);
        chk("act_l_12", 32'(dut.u_left.r_act), 12);
        hi_l = 0;
        repeat (16) begin hi_l += int'(en_l); @(negedge clk); end
        chk("en_l_hi_12", 32'(hi_l), 12);
        hi_l = 0; hi_r = 0;
        repeat (16) begin hi_l += int'(en_l); hi_r += int'(en_r); @(negedge clk); end
        chk("en_l_hi_15", 32'(hi_l), 15);
        chk("en_r_hi_15", 32'(hi_r), 15);
        dir = 4'b0101;
        wait_cyc(72); chk("veer_l_11", 32'(dut.u_left.r_cur), 11);
        chk("veer_r_15a", 32'(dut.u_right.r_cur), 15);
        wait_cyc(80); chk("veer_l_7", 32'(dut.u_left.r_cur), 7);
        wait_cyc(88); chk("veer_l_6", 32'(dut.u_left.r_cur), 6);
        chk("veer_r_15b", 32'(dut.u_right.r_cur), 15);
        wait_cyc(96); chk("veer_l_hold", 32'(dut.u_left.r_cur), 6);
        dir = 4'b1111;
        wait_cyc(97); chk("stop_lat", 32'(state), 1);
        wait_cyc(98); chk("stop_brake", 32'(state), 2);
        chk("brake_cur_clr", 32'(dut.u_left.r_cur), 0);
        ok = 0;
        repeat (20) begin
            if (state == 2'b10 && en_l && en_r && in1_l && in2_l && in1_r && in2_r) ok++;
            @(negedge clk);
        end
        chk("brake_20", 32'(ok), 20);
        chk("brake_end_idle", 32'(state), 0);
        chk("coast_en_l", 32'(en_l), 0);
        chk("coast_en_r", 32'(en_r), 0);
        chk("coast_in1_l", 32'(in1_l), 0);
        chk("coast_in2_r", 32'(in2_r), 0);
        wait_cyc(120); chk("stop_stays_idle", 32'(state), 0);
        dir = 4'b0000;
        wait_cyc(122); chk("rerun", 32'(state), 1);
        dir = 4'b1111;
        wait_cyc(124); chk("brake2", 32'(state), 2);
        dir = 4'b1001;
        wait_cyc(143); chk("brake2_hold", 32'(state), 2);
        wait_cyc(144); chk("brake2_idle", 32'(state), 0);
        wait_cyc(145); chk("restart_run", 32'(state), 1);
        chk("restart_in1_r", 32'(in1_r), 1);
        chk("restart_in2_r", 32'(in2_r), 0);
        chk("restart_cur0", 32'(dut.u_left.r_cur), 0);
        wait_cyc(152); chk("vr_l_4", 32'(dut.u_left.r_cur), 4);
        chk("vr_r_4", 32'(dut.u_right.r_cur), 4);
        wait_cyc(160); chk("vr_l_8", 32'(dut.u_left.r_cur), 8);
        chk("vr_r_6", 32'(dut.u_right.r_cur), 6);
        wait_cyc(176); chk("vr_l_15", 32'(dut.u_left.r_cur), 15);
        chk("vr_r_6b", 32'(dut.u_right.r_cur), 6);
        dir = 4'b0110;
        wait_cyc(177); chk("unk_lat", 32'(state), 1);
        wait_cyc(178); chk("unk_brake", 32'(state), 2);
        wait_cyc(185);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_en_l", 32'(en_l), 0);
        chk("mid_rst_in1_l", 32'(in1_l), 0);
        chk("mid_rst_in2_r", 32'(in2_r), 0);
        chk("mid_rst_act", 32'(dut.u_left.r_act), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(3); chk("no_resume", 32'(state), 0);
        chk("no_resume_en", 32'(en_l), 0);
        chk("no_resume_in1", 32'(in1_l), 0);
        wait_cyc(5); chk("no_resume2", 32'(state), 0);
        dir = 4'b0000;
        wait_cyc(7); chk("final_run", 32'(state), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
